// File: rtl/pattern_gen.sv
// pattern_gen
//   Emits the digit pattern 0-5-3-1 (sel=0) or 0-6-1-9 (sel=1) as a
//   qualified digit stream. The pattern is repeated 'reps' times, and
//   consecutive emissions are separated by 'gap' idle cycles. The
//   dout/valid pair connects directly to the digit-pattern detector's
//   din/enable inputs.
//
// Ports
//   clk    : clock; all state updates on the rising edge
//   reset  : asynchronous, active-high reset
//   start  : emission request; accepted only when busy=0
//   sel    : pattern select, sampled at accept
//   reps   : number of emissions, 0 treated as 1, sampled at accept
//   gap    : idle cycles between emissions, sampled at accept
//   stall  : freezes state and counters while high (no effect in IDLE)
//   dout   : current digit (FILL when not emitting)
//   valid  : digit qualifier; combinationally gated by stall
//   busy   : high in every non-IDLE state
//   done   : one-cycle completion pulse in the first IDLE cycle
module pattern_gen #(
  parameter int         CNT_W = 4,
  parameter logic [3:0] FILL  = 4'hF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sel,
  input  logic [CNT_W-1:0] reps,
  input  logic [CNT_W-1:0] gap,
  input  logic             stall,
  output logic [3:0]       dout,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    IDLE,
    D0,
    D1,
    D2,
    D3,
    GAP
  } state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state;
  logic             sel_q;
  logic [CNT_W-1:0] rep_left;
  logic [CNT_W-1:0] gap_q;
  logic [CNT_W-1:0] gap_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      sel_q    <= 1'b0;
      rep_left <= '0;
      gap_q    <= '0;
      gap_cnt  <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          // Stall is ignored here; start on the done cycle is accepted.
          if (start) begin
            sel_q    <= sel;
            rep_left <= (reps == '0) ? ONE : reps;
            gap_q    <= gap;
            state    <= D0;
          end
        end
        D0: if (!stall) state <= D1;
        D1: if (!stall) state <= D2;
        D2: if (!stall) state <= D3;
        D3: begin
          if (!stall) begin
            if (rep_left == ONE) begin
              state <= IDLE;
              done  <= 1'b1;
            end else begin
              rep_left <= rep_left - ONE;
              if (gap_q == '0) begin
                state <= D0;
              end else begin
                gap_cnt <= gap_q;
                state   <= GAP;
              end
            end
          end
        end
        GAP: begin
          if (!stall) begin
            gap_cnt <= gap_cnt - ONE;
            if (gap_cnt == ONE) state <= D0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Moore digit decode from the current state and latched select.
  always_comb begin
    dout = FILL;
    unique case (state)
      D0:      dout = 4'd0;
      D1:      dout = sel_q ? 4'd6 : 4'd5;
      D2:      dout = sel_q ? 4'd1 : 4'd3;
      D3:      dout = sel_q ? 4'd9 : 4'd1;
      default: dout = FILL;
    endcase
  end

  assign valid = (state inside {D0, D1, D2, D3}) & ~stall;
  assign busy  = (state != IDLE);

endmodule

// File: tb/tb_pattern_gen.sv
module tb_pattern_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       sel;
  logic [3:0] reps;
  logic [3:0] gap;
  logic       stall;
  logic [3:0] dout;
  logic       valid;
  logic       busy;
  logic       done;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pattern_gen #(
    .CNT_W (4),
    .FILL  (4'hF)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .sel   (sel),
    .reps  (reps),
    .gap   (gap),
    .stall (stall),
    .dout  (dout),
    .valid (valid),
    .busy  (busy),
    .done  (done)
  );

  // Reference model: a job is expanded into the list of cycles it occupies
  // when unstalled (digits and gap fills); a pointer walks that list and
  // advances on every non-stalled cycle.
  logic [3:0] exp_q[$];
  bit         dig_q[$];
  bit         m_active;
  int         m_idx;
  bit         m_done;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] digit(input logic s, input int k);
    logic [3:0] d;
    case (k)
      0:       d = 4'd0;
      1:       d = s ? 4'd6 : 4'd5;
      2:       d = s ? 4'd1 : 4'd3;
      default: d = s ? 4'd9 : 4'd1;
    endcase
    return d;
  endfunction

  task automatic build(input logic s, input logic [3:0] r, input logic [3:0] g);
    int rr;
    rr = (r == 0) ? 1 : int'(r);
    exp_q.delete();
    dig_q.delete();
    for (int e = 0; e < rr; e++) begin
      for (int k = 0; k < 4; k++) begin
        exp_q.push_back(digit(s, k));
        dig_q.push_back(1'b1);
      end
      if (e < rr - 1) begin
        for (int j = 0; j < int'(g); j++) begin
          exp_q.push_back(4'hF);
          dig_q.push_back(1'b0);
        end
      end
    end
    m_active = 1'b1;
    m_idx    = 0;
  endtask

  // One clock cycle: drive inputs just after the edge, check mid-cycle,
  // then advance the model to what the next edge should produce.
  task automatic step(input logic s, input logic sl, input logic [3:0] r,
                      input logic [3:0] g, input logic st);
    @(posedge clk);
    #1;
    start = s;
    sel   = sl;
    reps  = r;
    gap   = g;
    stall = st;
    #3;
    if (m_active) begin
      check("dout", dout, exp_q[m_idx]);
      check("valid", valid, dig_q[m_idx] & ~st);
      check("busy", busy, 1);
      check("done", done, 0);
    end else begin
      check("dout_idle", dout, 4'hF);
      check("valid_idle", valid, 0);
      check("busy_idle", busy, 0);
      check("done_idle", done, m_done);
    end
    if (m_active) begin
      m_done = 1'b0;
      if (!st) begin
        m_idx++;
        if (m_idx == exp_q.size()) begin
          m_active = 1'b0;
          m_done   = 1'b1;
        end
      end
    end else begin
      m_done = 1'b0;
      if (s) build(sl, r, g);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
  endtask

  // Reset lands mid-cycle; outputs must clear without waiting for an edge.
  task automatic async_reset();
    @(posedge clk);
    #2;
    reset = 1'b1;
    start = 1'b0;
    stall = 1'b0;
    #1;
    check("rst_dout", dout, 4'hF);
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    m_active = 1'b0;
    m_done   = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    sel      = 1'b0;
    reps     = '0;
    gap      = '0;
    stall    = 1'b0;
    m_active = 1'b0;
    m_idx    = 0;
    m_done   = 1'b0;
    #12;
    check("por_dout", dout, 4'hF);
    check("por_valid", valid, 0);
    check("por_busy", busy, 0);
    check("por_done", done, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Single emission, sel=0.
    step(1'b1, 1'b0, 4'd1, 4'd0, 1'b0);
    idle(6);

    // Two emissions with a gap of 2, sel=1.
    step(1'b1, 1'b1, 4'd2, 4'd2, 1'b0);
    idle(12);

    // Stall held for three cycles while in D1.
    step(1'b1, 1'b0, 4'd1, 4'd0, 1'b0);
    step(1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    repeat (3) step(1'b0, 1'b0, 4'd0, 4'd0, 1'b1);
    idle(5);

    // Start held high: ignored mid-job with flipped sel, accepted on done.
    step(1'b1, 1'b0, 4'd2, 4'd1, 1'b0);
    for (int i = 0; i < 30; i++)
      step(1'b1, logic'(i[0]), 4'(i % 3), 4'(i % 2), 1'b0);
    idle(20);

    // reps=0 behaves as a single emission.
    step(1'b1, 1'b1, 4'd0, 4'd3, 1'b0);
    idle(6);

    // Reset during D2 of a three-emission job, then a fresh sel=1 job.
    step(1'b1, 1'b0, 4'd3, 4'd1, 1'b0);
    step(1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    step(1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    async_reset();
    idle(3);
    step(1'b1, 1'b1, 4'd1, 4'd0, 1'b0);
    idle(6);

    // Random jobs with random stall.
    for (int i = 0; i < 800; i++) begin
      step(logic'($urandom_range(0, 9) < 3), logic'($urandom_range(0, 1)),
           4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
           logic'($urandom_range(0, 3) == 0));
    end
    idle(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
